// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC inter-stage skid register.
package cordic_pkg;

    localparam int unsigned CORDIC_WORD_LENGTH = 21;
    localparam int unsigned CORDIC_TAG_WIDTH   = 5;

    // Occupancy encoding doubles as the occupancy_o value.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } cordic_state_e;

    typedef struct packed {
        logic signed [CORDIC_WORD_LENGTH-1:0] x;
        logic signed [CORDIC_WORD_LENGTH-1:0] y;
        logic signed [CORDIC_WORD_LENGTH-1:0] z;
        logic [CORDIC_TAG_WIDTH-1:0]          tag;
    } cordic_entry_t;

    localparam int unsigned CORDIC_ENTRY_WIDTH = $bits(cordic_entry_t);

endpackage

// File: rtl/cordic_entry_reg.sv
// Load-enabled storage register for one {x,y,z,tag} entry, synchronous reset to a fill value.
module cordic_entry_reg #(
    parameter int unsigned WIDTH      = 68,
    parameter bit          RESET_DATA = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= {WIDTH{RESET_DATA}};
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/cordic_skid_reg.sv
// CORDIC inter-stage register with valid/ready handshake and a 2-entry skid buffer.
module cordic_skid_reg
    import cordic_pkg::*;
#(
    parameter int unsigned WORD_LENGTH = CORDIC_WORD_LENGTH,
    parameter int unsigned TAG_WIDTH   = CORDIC_TAG_WIDTH,
    parameter bit          RESET_DATA  = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [WORD_LENGTH-1:0] x_i,
    input  logic [WORD_LENGTH-1:0] y_i,
    input  logic [WORD_LENGTH-1:0] z_i,
    input  logic [TAG_WIDTH-1:0]   tag_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [WORD_LENGTH-1:0] x_o,
    output logic [WORD_LENGTH-1:0] y_o,
    output logic [WORD_LENGTH-1:0] z_o,
    output logic [TAG_WIDTH-1:0]   tag_o,
    output logic [1:0]             occupancy_o
);

    // Same layout as cordic_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [WORD_LENGTH-1:0] x;
        logic [WORD_LENGTH-1:0] y;
        logic [WORD_LENGTH-1:0] z;
        logic [TAG_WIDTH-1:0]   tag;
    } entry_t;

    localparam int unsigned EntryWidth = $bits(entry_t);

    cordic_state_e state_q, state_d;

    entry_t in_entry;
    entry_t main_q, main_d;
    entry_t skid_q;

    logic ready;
    logic valid;
    logic in_fire;
    logic out_fire;
    logic main_load;
    logic skid_load;
    logic main_from_skid;

    // Handshake outputs depend on registered state only.
    assign ready    = (state_q != ST_TWO);
    assign valid    = (state_q != ST_EMPTY);
    assign in_fire  = valid_i & ready;
    assign out_fire = valid & ready_i;

    assign in_entry = '{x: x_i, y: y_i, z: z_i, tag: tag_i};

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;

        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d   = ST_ONE;
                        main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        state_d   = ST_TWO;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_d        = ST_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : in_entry;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    cordic_entry_reg #(
        .WIDTH      (EntryWidth),
        .RESET_DATA (RESET_DATA)
    ) u_main_reg (
        .clk    (clk),
        .rst    (rst),
        .load_i (main_load),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    cordic_entry_reg #(
        .WIDTH      (EntryWidth),
        .RESET_DATA (RESET_DATA)
    ) u_skid_reg (
        .clk    (clk),
        .rst    (rst),
        .load_i (skid_load),
        .d_i    (in_entry),
        .q_o    (skid_q)
    );

    assign ready_o     = ready;
    assign valid_o     = valid;
    assign occupancy_o = state_q;
    assign x_o         = main_q.x;
    assign y_o         = main_q.y;
    assign z_o         = main_q.z;
    assign tag_o       = main_q.tag;

endmodule

// File: tb/tb_cordic_skid_reg.sv
// Self-checking bench for cordic_skid_reg against a 2-deep FIFO reference model.
module tb_cordic_skid_reg;

    localparam int unsigned W = 21;
    localparam int unsigned T = 5;

    typedef struct packed {
        logic signed [W-1:0] x;
        logic signed [W-1:0] y;
        logic signed [W-1:0] z;
        logic [T-1:0]        tag;
    } ent_t;

    logic                clk;
    logic                rst;
    logic                flush;
    logic                valid_i;
    logic                ready_o;
    logic signed [W-1:0] x_i, y_i, z_i;
    logic [T-1:0]        tag_i;
    logic                valid_o;
    logic                ready_i;
    logic signed [W-1:0] x_o, y_o, z_o;
    logic [T-1:0]        tag_o;
    logic [1:0]          occupancy_o;

    int checks;
    int failures;

    ent_t mq[$];

    cordic_skid_reg #(
        .WORD_LENGTH (W),
        .TAG_WIDTH   (T),
        .RESET_DATA  (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .x_i         (x_i),
        .y_i         (y_i),
        .z_i         (z_i),
        .tag_i       (tag_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .x_o         (x_o),
        .y_o         (y_o),
        .z_o         (z_o),
        .tag_o       (tag_o),
        .occupancy_o (occupancy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; the model is a FIFO of capacity 2 updated from the applied inputs.
    task automatic tick();
        bit   inf;
        bit   outf;
        ent_t cur;
        inf = valid_i && (mq.size() < 2);
        outf = (mq.size() > 0) && ready_i;
        cur = '{x: x_i, y: y_i, z: z_i, tag: tag_i};
        @(posedge clk);
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (outf) void'(mq.pop_front());
            if (inf) mq.push_back(cur);
        end
        #1;
    endtask

    function automatic logic signed [W-1:0] rnd_word();
        logic signed [W-1:0] v;
        v = W'($urandom);
        case ($urandom_range(0, 3))
            0: v = -(21'sd1 <<< 20);
            1: v = (21'sd1 <<< 20) - 21'sd1;
            default: ;
        endcase
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; valid_i = 1'b1; ready_i = 1'b1;
        x_i = 21'sd100; y_i = 21'sd3; z_i = 21'sd4; tag_i = 5'd7;
        tick();
        tick();
        rst = 1'b0; valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || occupancy_o !== 2'd0) begin
            failures++;
            $display("FAIL reset_flags: valid=%b ready=%b occ=%0d, want 0 1 0",
                     valid_o, ready_o, occupancy_o);
        end
        checks++;
        if (x_o !== 21'sd0 || y_o !== 21'sd0 || z_o !== 21'sd0 || tag_o !== 5'd0) begin
            failures++;
            $display("FAIL reset_data: x=%0d y=%0d z=%0d tag=%0d, want all 0",
                     x_o, y_o, z_o, tag_o);
        end
        tick();
        checks++;
        if (valid_o !== 1'b0 || occupancy_o !== 2'd0) begin
            failures++;
            $display("FAIL reset_no_capture: valid=%b occ=%0d, want 0 0", valid_o, occupancy_o);
        end
    endtask

    task automatic test_streaming();
        ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            valid_i = 1'b1;
            x_i = W'(i); y_i = -W'(i); z_i = 21'sh1FFFF; tag_i = T'(i - 1);
            tick();
            checks++;
            if (valid_o !== 1'b1 || ready_o !== 1'b1 || x_o !== W'(i) || y_o !== -W'(i)
                || z_o !== 21'sh1FFFF || tag_o !== T'(i - 1)) begin
                failures++;
                $display("FAIL stream_%0d: valid=%b ready=%b x=%0d y=%0d z=%h tag=%0d, want 1 1 %0d %0d 1ffff %0d",
                         i, valid_o, ready_o, x_o, y_o, z_o, tag_o, i, -i, i - 1);
            end
        end
        valid_i = 1'b0;
        tick();
        checks++;
        if (valid_o !== 1'b0 || occupancy_o !== 2'd0) begin
            failures++;
            $display("FAIL stream_drain: valid=%b occ=%0d, want 0 0", valid_o, occupancy_o);
        end
    endtask

    task automatic test_stall_skid();
        ready_i = 1'b0; valid_i = 1'b1;
        x_i = 21'sd5; y_i = 21'sd50; z_i = 21'sd500; tag_i = 5'd1;
        tick();
        x_i = -21'sd7; y_i = -21'sd70; z_i = -21'sd700; tag_i = 5'd2;
        tick();
        valid_i = 1'b0;
        checks++;
        if (occupancy_o !== 2'd2 || ready_o !== 1'b0 || valid_o !== 1'b1 || x_o !== 21'sd5
            || tag_o !== 5'd1) begin
            failures++;
            $display("FAIL skid_full: occ=%0d ready=%b valid=%b x=%0d tag=%0d, want 2 0 1 5 1",
                     occupancy_o, ready_o, valid_o, x_o, tag_o);
        end
        ready_i = 1'b1;
        #2;
        checks++;
        if (ready_o !== 1'b0) begin
            failures++;
            $display("FAIL ready_comb_path: ready_o=%b after ready_i rose, want 0", ready_o);
        end
        tick();
        checks++;
        if (valid_o !== 1'b1 || x_o !== -21'sd7 || z_o !== -21'sd700 || tag_o !== 5'd2
            || ready_o !== 1'b1 || occupancy_o !== 2'd1) begin
            failures++;
            $display("FAIL skid_b_out: valid=%b x=%0d z=%0d tag=%0d ready=%b occ=%0d, want 1 -7 -700 2 1 1",
                     valid_o, x_o, z_o, tag_o, ready_o, occupancy_o);
        end
        tick();
        checks++;
        if (valid_o !== 1'b0 || occupancy_o !== 2'd0) begin
            failures++;
            $display("FAIL skid_drain: valid=%b occ=%0d, want 0 0", valid_o, occupancy_o);
        end
    endtask

    task automatic test_flush();
        ready_i = 1'b0; valid_i = 1'b1;
        x_i = 21'sd1; tag_i = 5'd3;
        tick();
        x_i = 21'sd2; tag_i = 5'd4;
        tick();
        checks++;
        if (occupancy_o !== 2'd2) begin
            failures++;
            $display("FAIL flush_setup: occ=%0d, want 2", occupancy_o);
        end
        flush = 1'b1; x_i = 21'sd9; tag_i = 5'd9;
        tick();
        flush = 1'b0; valid_i = 1'b0;
        checks++;
        if (occupancy_o !== 2'd0 || valid_o !== 1'b0 || ready_o !== 1'b1) begin
            failures++;
            $display("FAIL flush_state: occ=%0d valid=%b ready=%b, want 0 0 1",
                     occupancy_o, valid_o, ready_o);
        end
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (valid_o !== 1'b0) begin
                failures++;
                $display("FAIL flush_discard_%0d: valid=%b x=%0d, want valid 0", i, valid_o, x_o);
            end
        end
    endtask

    task automatic test_mid_reset();
        ready_i = 1'b0; valid_i = 1'b1;
        x_i = 21'sd11; y_i = 21'sd12; z_i = 21'sd13; tag_i = 5'd14;
        tick();
        checks++;
        if (occupancy_o !== 2'd1 || x_o !== 21'sd11) begin
            failures++;
            $display("FAIL midrst_setup: occ=%0d x=%0d, want 1 11", occupancy_o, x_o);
        end
        rst = 1'b1; ready_i = 1'b1; valid_i = 1'b1;
        x_i = 21'sd33; y_i = 21'sd34; z_i = 21'sd35; tag_i = 5'd6;
        tick();
        rst = 1'b0; valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || occupancy_o !== 2'd0 || x_o !== 21'sd0
            || y_o !== 21'sd0 || z_o !== 21'sd0 || tag_o !== 5'd0) begin
            failures++;
            $display("FAIL midrst_state: valid=%b ready=%b occ=%0d x=%0d y=%0d z=%0d tag=%0d, want 0 1 0 0 0 0 0",
                     valid_o, ready_o, occupancy_o, x_o, y_o, z_o, tag_o);
        end
        tick();
        checks++;
        if (valid_o !== 1'b0) begin
            failures++;
            $display("FAIL midrst_no_capture: valid=%b, want 0", valid_o);
        end
    endtask

    task automatic test_random();
        logic hold;
        ent_t snap;
        for (int c = 0; c < 10000; c++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 2) != 0);
            flush   = ($urandom_range(0, 63) == 0);
            rst     = ($urandom_range(0, 499) == 0);
            x_i = rnd_word(); y_i = rnd_word(); z_i = rnd_word(); tag_i = T'($urandom);
            hold = valid_o && !ready_i && !flush && !rst;
            snap = '{x: x_o, y: y_o, z: z_o, tag: tag_o};
            tick();
            checks++;
            if (occupancy_o !== 2'(mq.size()) || valid_o !== (mq.size() > 0)
                || ready_o !== (mq.size() < 2)) begin
                failures++;
                $display("FAIL rand_flags c=%0d: occ=%0d valid=%b ready=%b, want occ %0d",
                         c, occupancy_o, valid_o, ready_o, mq.size());
            end
            if (mq.size() > 0) begin
                checks++;
                if (x_o !== mq[0].x || y_o !== mq[0].y || z_o !== mq[0].z
                    || tag_o !== mq[0].tag) begin
                    failures++;
                    $display("FAIL rand_data c=%0d: got %0d %0d %0d %0d, want %0d %0d %0d %0d",
                             c, x_o, y_o, z_o, tag_o, mq[0].x, mq[0].y, mq[0].z, mq[0].tag);
                end
            end
            if (hold) begin
                checks++;
                if (valid_o !== 1'b1 || x_o !== snap.x || y_o !== snap.y || z_o !== snap.z
                    || tag_o !== snap.tag) begin
                    failures++;
                    $display("FAIL rand_stable c=%0d: valid=%b x=%0d, want 1 %0d",
                             c, valid_o, x_o, snap.x);
                end
            end
        end
        rst = 1'b0; flush = 1'b0; valid_i = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0; flush = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        x_i = '0; y_i = '0; z_i = '0; tag_i = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_streaming();
        test_stall_skid();
        test_flush();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
